msk_rnd_source: RTL and testbench
=================================

Name: msk_rnd_source

Overview:
- Randomness producer for masked gadgets (refresh, multipliers); it drives their `rnd` buses.
- A bank of 32-bit xorshift32 lanes is loaded through a seed handshake, runs a warm-up phase, then delivers one fresh RND_W-bit word per accepted transfer.
- Sits between the top-level seed/TRNG interface and the gadget `rnd` inputs. Gadgets with no backpressure tie rnd_ready high.

Parameters:
- RND_W, 8, output randomness width in bits (1..512); gadget random counts are derived from d and fixed by the integrator.
- WARMUP, 16, number of free-running steps after seeding, before the first valid output (0..255).
- LANES, derived = (RND_W+31)/32, number of xorshift32 lanes; localparam only, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- seed_in  in  32  one seed word per beat; lane 0 is loaded first.
- seed_valid  in  1  seed word present.
- seed_ready  out  1  block accepts a seed word.
- reseed_req  in  1  pulse: discard the current state and restart seeding.
- rnd  out  RND_W  randomness word; registered, driven directly from lane state.
- rnd_valid  out  1  rnd is fresh and unused.
- rnd_ready  in  1  consumer takes rnd this cycle.
- busy  out  1  high in SEED or WARM.

Behaviour:
- Reset, on a rising edge with rst_n=0:
  - state=IDLE; all lane registers = 32'h0000_0001; lane counter=0; warm counter=0.
  - Outputs: seed_ready=0, rnd_valid=0, busy=0. rnd shows the lane registers, so it reads 1 per lane and is meaningless while rnd_valid=0.
- xorshift32 step, per lane, in this order: x^=x<<13; x^=x>>17; x^=x<<5; 32-bit truncation.
  - All lanes step together, in one cycle.
  - Lane i drives rnd[32i+31:32i]; the top lane is truncated to fit RND_W.
- States:
  - IDLE: seed_ready=0. Moves to SEED on the next cycle unconditionally. A seed is never implicit; IDLE lasts exactly one cycle after reset.
  - SEED: seed_ready=1, busy=1.
    - Each beat with seed_valid&&seed_ready writes seed_in into lane[lane_cnt] and increments lane_cnt.
    - A zero seed word is stored as 32'hA5A5_A5A5 ^ lane index, because zero is a fixed point of xorshift32.
    - The beat that loads lane LANES-1 clears lane_cnt and moves to WARM, or straight to RUN when WARMUP=0.
  - WARM: busy=1, seed_ready=0.
    - All lanes step every cycle; warm_cnt increments.
    - When warm_cnt reaches WARMUP-1 on a stepping cycle, move to RUN and clear warm_cnt.
    - WARM therefore lasts exactly WARMUP cycles.
  - RUN: rnd_valid=1, busy=0.
    - A cycle with rnd_ready=1 steps all lanes, so rnd changes on the next edge.
    - With rnd_ready=0, rnd holds stable.
    - rnd_ready=1 held continuously yields a new word every cycle (full throughput).
- Latency: after reset, the first rnd_valid appears 1 + LANES + WARMUP cycles later, assuming seed_valid is held high.
- Reseed:
  - reseed_req=1 in any state except IDLE moves to SEED on the next edge: lane_cnt=0, warm_cnt=0, rnd_valid drops.
  - Lane registers keep their values until they are overwritten.
  - The reseed takes priority over a same-cycle seed beat, which is not accepted, and over a same-cycle rnd transfer, which is still taken by the consumer but does not step the lanes.
- rst_n=0 mid-operation: returns to IDLE at that edge, whatever the handshake state.
- Seeding is incomplete, with seed_valid low partway through: remain in SEED with lane_cnt frozen; no timeout.
- rnd_valid never rises outside RUN. rnd never changes in RUN unless a transfer occurs.

Decomposition:
- Shared package msk_rnd_pkg:
  - state enum {IDLE, SEED, WARM, RUN};
  - XS_A=13, XS_B=17, XS_C=5;
  - ZERO_SEED_SUB=32'hA5A5_A5A5;
  - function lanes(rnd_w).
- Sub-module msk_xorshift32_lane:
  - one 32-bit register with load, step and hold controls, plus zero-seed substitution;
  - instantiated LANES times by a generate loop.
- The top level holds the FSM, the lane and warm counters, and the output packing.

Test Plan:
- RND_W=8, WARMUP=0, seed 32'h1 → rnd_valid rises 2 cycles after reset; rnd=8'h01. One transfer → rnd=8'h21 (state 32'h0004_2021).
- RND_W=64, WARMUP=0, seed 32'h0 then 32'h1 → lane0 loads 32'hA5A5_A5A5 and lane1 loads 32'h1; the upper 32 bits of the first rnd = 32'h0000_0001.
- RND_W=8, WARMUP=1, seed 32'h1 → busy for 2 cycles; first valid rnd=8'h21, equal to the lane state after one step.
- RUN with rnd_ready=0 for 5 cycles → rnd constant; rnd_ready=1 for 3 cycles → 3 distinct successive xorshift values.
- reseed_req during RUN, in a cycle that also has rnd_ready=1 → rnd_valid=0 on the next edge, seed_ready=1, lane state unstepped; after reseeding with 32'h1 and WARMUP=0 → rnd=8'h01 again.
- rst_n=0 in the middle of SEED, after lane 0 of 2 is loaded → next state IDLE, every lane reads 32'h1, seed_ready=0 for one cycle, then SEED restarts at lane 0.

Source files
------------

// File: rtl/msk_rnd_pkg.sv
// Shared constants and helpers for the masked-gadget randomness source.
package msk_rnd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEED = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;

  localparam logic [31:0] ZERO_SEED_SUB = 32'hA5A5_A5A5;

  function automatic int lanes(input int rnd_w);
    return (rnd_w + 31) / 32;
  endfunction

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << XS_A);
    t = t ^ (t >> XS_B);
    t = t ^ (t << XS_C);
    return t;
  endfunction

endpackage

// File: rtl/msk_xorshift32_lane.sv
// One xorshift32 lane: load (with zero-seed substitution), step, or hold.
module msk_xorshift32_lane
  import msk_rnd_pkg::*;
#(
  parameter int IDX   = 0,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [31:0]      seed,
  output logic [OUT_W-1:0] rnd_o
);

  logic [31:0] state_q, state_d;
  logic [31:0] seed_fix;

  // Zero is a fixed point of xorshift32, so never let it into the register.
  assign seed_fix = (seed == 32'h0) ? (ZERO_SEED_SUB ^ 32'(IDX)) : seed;

  always_comb begin
    state_d = state_q;
    if (load)      state_d = seed_fix;
    else if (step) state_d = xs_step(state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= 32'h0000_0001;
    else        state_q <= state_d;
  end

  assign rnd_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/msk_rnd_source.sv
// Seeded bank of xorshift32 lanes feeding masked-gadget rnd buses.
module msk_rnd_source
  import msk_rnd_pkg::*;
#(
  parameter int RND_W  = 8,
  parameter int WARMUP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      seed_in,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic             reseed_req,
  output logic [RND_W-1:0] rnd,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             busy
);

  localparam int LANES = lanes(RND_W);
  localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;

  logic [1:0]     state_q, state_d;
  logic [LCW-1:0] lane_cnt_q, lane_cnt_d;
  logic [7:0]     warm_cnt_q, warm_cnt_d;
  logic           load_en, step_en;

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    warm_cnt_d = warm_cnt_q;
    load_en    = 1'b0;
    step_en    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_SEED;
      ST_SEED: begin
        if (reseed_req) begin
          lane_cnt_d = '0;
          warm_cnt_d = '0;
        end else if (seed_valid) begin
          load_en = 1'b1;
          if (lane_cnt_q == LCW'(LANES - 1)) begin
            lane_cnt_d = '0;
            state_d    = (WARMUP == 0) ? ST_RUN : ST_WARM;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end
      ST_WARM: begin
        if (reseed_req) begin
          state_d    = ST_SEED;
          lane_cnt_d = '0;
          warm_cnt_d = '0;
        end else begin
          step_en = 1'b1;
          if (warm_cnt_q == 8'(WARMUP - 1)) begin
            warm_cnt_d = '0;
            state_d    = ST_RUN;
          end else begin
            warm_cnt_d = warm_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        // A reseed wins over a same-cycle transfer: lanes stay unstepped.
        if (reseed_req) begin
          state_d    = ST_SEED;
          lane_cnt_d = '0;
          warm_cnt_d = '0;
        end else begin
          step_en = rnd_ready;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lane_cnt_q <= '0;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int W = (i == LANES - 1) ? (RND_W - 32 * i) : 32;
    msk_xorshift32_lane #(.IDX(i), .OUT_W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_en && (lane_cnt_q == LCW'(i))),
      .step  (step_en),
      .seed  (seed_in),
      .rnd_o (rnd[32*i +: W])
    );
  end

  assign seed_ready = (state_q == ST_SEED);
  assign busy       = (state_q == ST_SEED) || (state_q == ST_WARM);
  assign rnd_valid  = (state_q == ST_RUN);

endmodule

// File: tb/tb_msk_rnd_source.sv
// Directed bench: three configurations (8b/no warm-up, 64b/no warm-up, 8b/warm-up 1).
module tb_msk_rnd_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // A: RND_W=8 WARMUP=0
  logic rst_a, sv_a, sr_a, rq_a, rv_a, rr_a, bz_a;
  logic [31:0] si_a;
  logic [7:0]  rnd_a;
  // B: RND_W=64 WARMUP=0
  logic rst_b, sv_b, sr_b, rq_b, rv_b, rr_b, bz_b;
  logic [31:0] si_b;
  logic [63:0] rnd_b;
  // C: RND_W=8 WARMUP=1
  logic rst_c, sv_c, sr_c, rq_c, rv_c, rr_c, bz_c;
  logic [31:0] si_c;
  logic [7:0]  rnd_c;

  msk_rnd_source #(.RND_W(8), .WARMUP(0)) dut_a (
    .clk(clk), .rst_n(rst_a), .seed_in(si_a), .seed_valid(sv_a), .seed_ready(sr_a),
    .reseed_req(rq_a), .rnd(rnd_a), .rnd_valid(rv_a), .rnd_ready(rr_a), .busy(bz_a));
  msk_rnd_source #(.RND_W(64), .WARMUP(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .seed_in(si_b), .seed_valid(sv_b), .seed_ready(sr_b),
    .reseed_req(rq_b), .rnd(rnd_b), .rnd_valid(rv_b), .rnd_ready(rr_b), .busy(bz_b));
  msk_rnd_source #(.RND_W(8), .WARMUP(1)) dut_c (
    .clk(clk), .rst_n(rst_c), .seed_in(si_c), .seed_valid(sv_c), .seed_ready(sr_c),
    .reseed_req(rq_c), .rnd(rnd_c), .rnd_valid(rv_c), .rnd_ready(rr_c), .busy(bz_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 0; sv_a = 0; si_a = 0; rq_a = 0; rr_a = 0;
    rst_b = 0; sv_b = 0; si_b = 0; rq_b = 0; rr_b = 0;
    rst_c = 0; sv_c = 0; si_c = 0; rq_c = 0; rr_c = 0;

    // ---- A: latency, first word, transfer, reseed priority
    sv_a = 1; si_a = 32'h1;
    tick();
    check("a_rst_seed_ready", 64'(sr_a), 64'd0);
    check("a_rst_valid",      64'(rv_a), 64'd0);
    check("a_rst_busy",       64'(bz_a), 64'd0);
    check("a_rst_rnd",        64'(rnd_a), 64'h01);
    rst_a = 1;
    tick();
    check("a_seed_ready",     64'(sr_a), 64'd1);
    check("a_seed_busy",      64'(bz_a), 64'd1);
    check("a_seed_valid_lo",  64'(rv_a), 64'd0);
    tick();
    check("a_first_valid",    64'(rv_a), 64'd1);
    check("a_first_rnd",      64'(rnd_a), 64'h01);
    check("a_run_busy",       64'(bz_a), 64'd0);
    sv_a = 0; rr_a = 1;
    tick();
    check("a_xfer_rnd",       64'(rnd_a), 64'h21);
    rr_a = 1; rq_a = 1;
    tick();
    check("a_reseed_valid",   64'(rv_a), 64'd0);
    check("a_reseed_sready",  64'(sr_a), 64'd1);
    check("a_reseed_nostep",  64'(rnd_a), 64'h21);
    rq_a = 0; rr_a = 0; sv_a = 1; si_a = 32'h1;
    tick();
    check("a_reseed_valid2",  64'(rv_a), 64'd1);
    check("a_reseed_rnd",     64'(rnd_a), 64'h01);
    sv_a = 0;

    // ---- B: zero-seed substitution, hold, throughput, reset mid-SEED
    sv_b = 1; si_b = 32'h0;
    tick();
    check("b_rst_rnd",        rnd_b, 64'h0000_0001_0000_0001);
    rst_b = 1;
    tick();
    check("b_seed_ready",     64'(sr_b), 64'd1);
    tick();
    si_b = 32'h1;
    check("b_lane1_pending",  64'(sr_b), 64'd1);
    tick();
    check("b_first_valid",    64'(rv_b), 64'd1);
    check("b_first_rnd",      rnd_b, 64'h0000_0001_A5A5_A5A5);
    sv_b = 0; rr_b = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_hold_rnd",     rnd_b, 64'h0000_0001_A5A5_A5A5);
      check("b_hold_valid",   64'(rv_b), 64'd1);
    end
    rr_b = 1;
    tick();
    check("b_step1_hi",       64'(rnd_b[63:32]), 64'h0004_2021);
    tick();
    check("b_step2_hi",       64'(rnd_b[63:32]), 64'h0408_0601);
    tick();
    check("b_step3_hi",       64'(rnd_b[63:32]), 64'h9DCC_A8C5);
    rr_b = 0; rq_b = 1;
    tick();
    check("b_reseed_sready",  64'(sr_b), 64'd1);
    rq_b = 0; sv_b = 1; si_b = 32'h1234_5678;
    tick();
    check("b_lane0_loaded",   64'(rnd_b[31:0]), 64'h1234_5678);
    check("b_mid_seed",       64'(sr_b), 64'd1);
    rst_b = 0; sv_b = 0;
    tick();
    check("b_midrst_sready",  64'(sr_b), 64'd0);
    check("b_midrst_busy",    64'(bz_b), 64'd0);
    check("b_midrst_rnd",     rnd_b, 64'h0000_0001_0000_0001);
    rst_b = 1;
    tick();
    check("b_resume_sready",  64'(sr_b), 64'd1);
    sv_b = 1; si_b = 32'h7;
    tick();
    check("b_resume_lane0",   rnd_b, 64'h0000_0001_0000_0007);
    check("b_resume_seeding", 64'(sr_b), 64'd1);
    sv_b = 0;

    // ---- C: one warm-up step before first valid word
    sv_c = 1; si_c = 32'h1;
    tick();
    rst_c = 1;
    tick();
    check("c_seed_busy",      64'(bz_c), 64'd1);
    check("c_seed_ready",     64'(sr_c), 64'd1);
    tick();
    check("c_warm_busy",      64'(bz_c), 64'd1);
    check("c_warm_sready",    64'(sr_c), 64'd0);
    check("c_warm_valid",     64'(rv_c), 64'd0);
    check("c_warm_rnd",       64'(rnd_c), 64'h01);
    tick();
    check("c_run_busy",       64'(bz_c), 64'd0);
    check("c_run_valid",      64'(rv_c), 64'd1);
    check("c_run_rnd",        64'(rnd_c), 64'h21);
    sv_c = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
